// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input conditioner: edge-select encoding,
// counter sizing and edge qualification.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_t;

  // Debounce counter must hold values up to DEBOUNCE_CYCLES-1 at least.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // An accepted update always toggles the level, so the new value alone
  // tells us which edge it was.
  function automatic logic edge_qualifies(input edge_mode_t mode, input logic new_level);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_FALL: hit = ~new_level;
      EDGE_RISE: hit = new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cond_channel.sv
// One input channel: metastability chain, counter debouncer, registered
// edge pulse. pulse_next is exported so the top can register the OR in step.
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  input  edge_mode_t edge_mode,
  input  logic       chan_en,
  output logic       level,
  output logic       pulse_next,
  output logic       pulse
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   flip;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync       = sync_q[SYNC_STAGES-1];
  assign flip       = (sync != level) && (cnt == CNT_LAST);
  assign pulse_next = flip && chan_en && edge_qualifies(edge_mode, sync);

  // Any cycle where sync agrees with level wipes the count: no partial credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= RESET_LEVEL;
      pulse <= 1'b0;
    end else begin
      pulse <= pulse_next;
      if (sync == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions CHANNELS asynchronous pins into debounced levels and
// single-cycle edge events in the clk domain.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [1:0]          edge_mode_i,
  input  logic [CHANNELS-1:0] chan_en_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] pulse_o,
  output logic                any_pulse_o
);

  edge_mode_t          mode;
  logic [CHANNELS-1:0] pulse_next;

  assign mode = edge_mode_t'(edge_mode_i);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_i[c]),
      .edge_mode (mode),
      .chan_en   (chan_en_i[c]),
      .level     (level_o[c]),
      .pulse_next(pulse_next[c]),
      .pulse     (pulse_o[c])
    );
  end

  // Registered from the same next-state terms so it lines up with pulse_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_pulse_o <= 1'b0;
    else        any_pulse_o <= |pulse_next;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model.
module tb_input_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] raw_i;
  logic [1:0]    edge_mode_i;
  logic [CH-1:0] chan_en_i;
  logic [CH-1:0] level_o;
  logic [CH-1:0] pulse_o;
  logic          any_pulse_o;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_i), .edge_mode_i(edge_mode_i),
    .chan_en_i(chan_en_i), .level_o(level_o), .pulse_o(pulse_o),
    .any_pulse_o(any_pulse_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a delay queue per pin, then a window of the last DC
  // synchronized samples; the level flips once the whole window disagrees.
  bit         dq[CH][$];
  bit         wq[CH][$];
  logic [CH-1:0] m_level, m_pulse;
  logic          m_any;

  function automatic bit wants(input logic [1:0] mode, input bit nl);
    case (mode)
      2'b00:   return !nl;
      2'b01:   return nl;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      dq[c].delete();
      wq[c].delete();
      for (int s = 0; s < SS; s++) dq[c].push_back(1'b0);
    end
    m_level = '0;
    m_pulse = '0;
    m_any   = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] np;
    np = '0;
    for (int c = 0; c < CH; c++) begin
      bit s;
      int mism;
      s = dq[c].pop_front();
      dq[c].push_back(raw_i[c]);
      wq[c].push_back(s);
      if (wq[c].size() > DC) void'(wq[c].pop_front());
      mism = 0;
      foreach (wq[c][k]) if (wq[c][k] != m_level[c]) mism++;
      if (mism == DC) begin
        m_level[c] = s;
        wq[c].delete();
        np[c] = chan_en_i[c] && wants(edge_mode_i, s);
      end
    end
    m_pulse = np;
    m_any   = |np;
  endtask

  // Inputs are changed only at the falling edge, so the model reads the same
  // values the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_level", level_o, m_level);
    check("model_pulse", pulse_o, m_pulse);
    check("model_any", any_pulse_o, m_any);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [CH-1:0] raw;
    logic [1:0]    mode;
    logic [CH-1:0] lvl;
    logic [CH-1:0] pls;
    logic          any;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int cnt, at;

    // Channel 0: rise in RISE mode, fall in RISE mode, rise in FALL mode.
    for (int i = 0; i < 24; i++) begin
      int seg, k;
      seg = i / 8;
      k   = i % 8;
      tbl[i].raw  = (seg == 1) ? 4'h0 : 4'h1;
      tbl[i].mode = (seg == 2) ? 2'b00 : 2'b01;
      tbl[i].lvl  = (seg == 1) ? ((k < 5) ? 4'h1 : 4'h0) : ((k >= 5) ? 4'h1 : 4'h0);
      tbl[i].pls  = (seg == 0 && k == 5) ? 4'h1 : 4'h0;
      tbl[i].any  = (seg == 0 && k == 5);
    end

    rst_n = 1'b0;
    raw_i = '0;
    edge_mode_i = 2'b01;
    chan_en_i = 4'hF;
    model_reset();
    #12;
    check("reset_level", level_o, 4'h0);
    check("reset_pulse", pulse_o, 4'h0);
    check("reset_any", any_pulse_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_level", level_o, 4'h0);
      check("idle_pulse", {any_pulse_o, pulse_o}, 5'h0);
    end

    // Table
    for (int i = 0; i < 24; i++) begin
      raw_i = tbl[i].raw;
      edge_mode_i = tbl[i].mode;
      tick();
      check("tbl_level", level_o, tbl[i].lvl);
      check("tbl_pulse", pulse_o, tbl[i].pls);
      check("tbl_any", any_pulse_o, tbl[i].any);
    end
    raw_i = '0;
    run(10);

    // Bounce on channel 1, mode BOTH
    edge_mode_i = 2'b10;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      raw_i[1] = (i >= 8) ? 1'b1 : ((i % 4) < 2);
      tick();
      if (pulse_o[1]) cnt++;
      if (i < 13) check("bounce_hold", level_o[1], 1'b0);
      if (i == 13) check("bounce_accept", level_o[1], 1'b1);
    end
    check("bounce_pulses", cnt, 1);

    // Falling release on channel 2, then again with pulses disabled
    raw_i[2] = 1'b1;
    run(10);
    raw_i[2] = 1'b0;
    cnt = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulse_o[2]) cnt++;
      if (level_o[2] == 1'b0 && at < 0) at = i;
    end
    check("fall_pulses", cnt, 1);
    check("fall_latency", at, 5);
    raw_i[2] = 1'b1;
    run(10);
    chan_en_i[2] = 1'b0;
    raw_i[2] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulse_o[2]) cnt++;
    end
    check("dis_pulses", cnt, 0);
    check("dis_level", level_o[2], 1'b0);
    chan_en_i = 4'hF;

    // Simultaneous rise on all channels
    raw_i = '0;
    run(10);
    edge_mode_i = 2'b01;
    raw_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) begin
        check("simul_pulse", pulse_o, 4'hF);
        check("simul_any", any_pulse_o, 1'b1);
      end
    end

    // Reset in the middle of a debounce on channel 3
    raw_i = '0;
    run(10);
    raw_i[3] = 1'b1;
    run(4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_level", level_o, 4'h0);
    check("midrst_pulse", {any_pulse_o, pulse_o}, 5'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_relvl", level_o[3], (i == 5));
      check("midrst_repls", pulse_o[3], (i == 5));
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) raw_i[$urandom_range(CH-1)] ^= 1'b1;
      if ($urandom_range(39) == 0) edge_mode_i = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) chan_en_i = 4'($urandom_range(15));
      if ($urandom_range(149) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_rst_level", level_o, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the team's single-bit synchronizer/falling-edge detector.
- Conditions CHANNELS asynchronous inputs (push buttons, switches, external strobes) into the clk domain. Per channel it provides a metastability chain, a counter-based debouncer, and a one-cycle edge pulse with runtime-selectable edge polarity.
- Sits between board pins and the control FSMs and VGA logic. Downstream logic consumes either the debounced level or the single-cycle event.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: flip-flops in each synchronizer chain (>=2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a changed synchronized value must persist before it is accepted (>=1).
- RESET_LEVEL, 1'b0: reset value of every sync stage and debounced level (idle level of the inputs).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- raw_i, in, CHANNELS: asynchronous raw inputs.
- edge_mode_i, in, 2: global edge select. 2'b00 = falling, 2'b01 = rising, 2'b10 = both, 2'b11 = none.
- chan_en_i, in, CHANNELS: per-channel pulse enable. Disabled channels keep tracking level but never pulse.
- level_o, out, CHANNELS: debounced, synchronized level.
- pulse_o, out, CHANNELS: one-cycle event pulse per channel.
- any_pulse_o, out, 1: OR of pulse_o, registered together with pulse_o.

Behaviour:
- Reset (rst_n low, async):
  - All sync stages = RESET_LEVEL.
  - level_o = {CHANNELS{RESET_LEVEL}}.
  - Debounce counters = 0.
  - pulse_o = 0, any_pulse_o = 0.
- Reset is released synchronously to clk externally. No pulse may be generated on the first cycle after release unless a real debounced change occurs.
- Sync chain:
  - raw_i[c] shifts through SYNC_STAGES flops every clk edge.
  - sync[c] is the last stage.
  - No logic is permitted between stages.
- Debouncer, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == level: counter <= 0.
  - sync != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != level and counter == DEBOUNCE_CYCLES-1: level <= sync, counter <= 0.
  - Any single cycle where sync returns to level clears the counter (glitch rejected; no partial credit).
- Latency: a raw change stable for the whole window reaches level_o exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Edge pulse:
  - Registered. pulse_o[c] is high in the same cycle level_o[c] first shows its new value, for exactly one cycle.
  - Qualified by edge_mode_i as sampled on the edge where level updates: falling = 1->0, rising = 0->1, both = either, none = never.
  - Also gated by chan_en_i[c] on that same edge.
  - A channel cannot pulse on consecutive cycles (min spacing DEBOUNCE_CYCLES).
- Simultaneous events: channels are fully independent. Several pulse_o bits may assert in the same cycle; any_pulse_o then = 1.
- edge_mode_i or chan_en_i changing mid-debounce affects only the qualification of the eventual update. Counters and levels are unaffected.
- Reset mid-debounce: counter and level return to reset values immediately. Any pending transition is discarded, no pulse.

Decomposition:
- Package input_conditioner_pkg:
  - typedef enum logic [1:0] edge_mode_t {EDGE_FALL, EDGE_RISE, EDGE_BOTH, EDGE_NONE}.
  - Function for counter width.
- Sub-module cond_channel: one channel (sync chain, debounce counter, level, pulse).
- Top instantiates CHANNELS copies via generate and ORs pulses for any_pulse_o.

Test Plan:
All scenarios use CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, chan_en_i=4'hF.
1. Reset and idle: raw_i=0, edge_mode_i=RISE, run 20 cycles -> level_o=0, pulse_o=0, any_pulse_o=0 throughout.
2. Clean rising press: raw_i[0] 0->1 held -> level_o[0]=1 exactly 6 edges later; pulse_o[0]=1 for that one cycle only. With edge_mode_i=FALL: level changes, no pulse.
3. Bounce rejection: raw_i[1] toggles 1,0,1,0 each 2 cycles, then holds 1 -> no level change until 4 consecutive synced 1s; exactly one pulse with mode BOTH.
4. Falling release with BOTH: channel 2 at level 1, raw_i[2]->0 -> level_o[2]=0 after 6 edges, single pulse. Same again with chan_en_i[2]=0 -> level updates, no pulse.
5. Simultaneous: raw_i=4'b1111 at once, mode RISE -> pulse_o=4'hF in one cycle, any_pulse_o=1 same cycle.
6. Reset mid-debounce: raw_i[3]=1, assert rst_n=0 after 4 edges, release -> level_o[3]=0 immediately at assertion, no pulse; full 6-edge latency restarts after release.
